// File: rtl/insa_sec_pkg.sv
// Shared security-block types: op codes, store-size encoding and the range record
// used by the heap overflow monitor.
package insa_sec_pkg;

  typedef enum logic [1:0] {
    OTHER = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    JALR  = 2'd3
  } hom_op_t;

  localparam logic [1:0] HOM_SZ_BYTE = 2'd0;
  localparam logic [1:0] HOM_SZ_HALF = 2'd1;
  localparam logic [1:0] HOM_SZ_WORD = 2'd2;
  localparam logic [1:0] HOM_SZ_NONE = 2'd3;

  localparam logic [0:0] HOM_ST_IDLE  = 1'b0;
  localparam logic [0:0] HOM_ST_TRACK = 1'b1;

  // Range records are sized for the widest supported address; narrower builds
  // zero-extend, so the constant upper bits disappear in synthesis.
  localparam int HOM_ADDR_W = 64;

  typedef struct packed {
    logic [HOM_ADDR_W-1:0] start_addr;
    logic [HOM_ADDR_W-1:0] end_addr;
    logic                  valid;
  } hom_range_t;

  function automatic logic [2:0] hom_size_bytes(input logic [1:0] size);
    logic [2:0] bytes;
    case (size)
      HOM_SZ_BYTE: bytes = 3'd1;
      HOM_SZ_HALF: bytes = 3'd2;
      HOM_SZ_WORD: bytes = 3'd4;
      default:     bytes = 3'd0;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/hom_range_buf.sv
// Circular buffer of committed address ranges with a parallel inclusive hit lookup.
// Macro HOM_OVERWRITE_OLDEST_EN: a write to a full buffer replaces the oldest entry.
module hom_range_buf
  import insa_sec_pkg::*;
#(
  parameter int NR_RANGES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         wr_en_i,
  input  hom_range_t                   wr_range_i,
  input  logic [HOM_ADDR_W-1:0]        lookup_addr_i,
  output logic                         hit_o,
  output logic                         lost_o,
  output logic [$clog2(NR_RANGES):0]   used_o
);

  localparam int PW = $clog2(NR_RANGES);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(NR_RANGES);

  hom_range_t      r_ranges [NR_RANGES];
  logic [PW-1:0]   r_wrPtr;
  logic [PW:0]     r_used;
  logic            w_full;
  logic            w_doWrite;
  logic            w_hit;

  assign w_full = (r_used == FULL_CNT);

`ifdef HOM_OVERWRITE_OLDEST_EN
  // When full the write pointer sits on the oldest entry, so a plain write evicts it.
  assign w_doWrite = wr_en_i;
  assign lost_o    = 1'b0;
`else
  assign w_doWrite = wr_en_i && !w_full;
  assign lost_o    = wr_en_i && w_full;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_RANGES; i++) r_ranges[i] <= '0;
      r_wrPtr <= '0;
      r_used  <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NR_RANGES; i++) r_ranges[i] <= '0;
      r_wrPtr <= '0;
      r_used  <= '0;
    end else if (w_doWrite) begin
      r_ranges[r_wrPtr] <= wr_range_i;
      r_wrPtr           <= r_wrPtr + PW'(1);
      if (!w_full) r_used <= r_used + (PW+1)'(1);
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NR_RANGES; i++) begin
      if (r_ranges[i].valid &&
          (r_ranges[i].start_addr <= lookup_addr_i) &&
          (lookup_addr_i <= r_ranges[i].end_addr)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign hit_o  = w_hit;
  assign used_o = r_used;

endmodule

// File: rtl/heap_overflow_monitor.sv
// Tracks runs of contiguous non-stack stores, records long runs as heap ranges and
// flags a JALR that follows a load from such a range. Honors HOM_OVERWRITE_OLDEST_EN.
module heap_overflow_monitor
  import insa_sec_pkg::*;
#(
  parameter int NR_RANGES     = 4,
  parameter int AW            = 32,
  parameter int MIN_RUN_BYTES = 32,
  parameter int TIMEOUT       = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  input  hom_op_t                    op_i,
  input  logic [1:0]                 size_i,
  input  logic [AW-1:0]              addr_i,
  input  logic                       stack_base_i,
  input  logic                       flush_i,
  input  logic                       en_crash_i,
  output logic                       crash_o,
  output logic                       tracking_o,
  output logic                       taint_o,
  output logic [$clog2(NR_RANGES):0] used_o,
  output logic                       drop_o
);

  localparam int DW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DATE_RELOAD = DW'(TIMEOUT);
  localparam logic [16:0]   MIN_RUN     = 17'(MIN_RUN_BYTES);

  logic [0:0]    r_state;
  logic [AW-1:0] r_start;
  logic [AW-1:0] r_end;
  logic [15:0]   r_count;
  logic [DW-1:0] r_date;
  logic          r_taint;
  logic          r_crash;
  logic          r_drop;

  logic          w_tracking;
  logic          w_qualStore;
  logic          w_nonStore;
  logic [2:0]    w_bytes;
  logic          w_contig;
  logic          w_timeout;
  logic          w_commit;
  logic          w_commitKeep;
  logic [16:0]   w_countSum;
  logic          w_liveHit;
  logic          w_bufHit;
  logic          w_bufLost;
  hom_range_t    w_wrRange;

  assign w_tracking  = (r_state == HOM_ST_TRACK);
  assign w_qualStore = valid_i && (op_i == STORE) && !stack_base_i && (size_i != HOM_SZ_NONE);
  assign w_nonStore  = valid_i && (op_i != STORE);
  assign w_bytes     = hom_size_bytes(size_i);
  assign w_contig    = ((r_end + AW'(w_bytes)) == addr_i);
  assign w_timeout   = w_nonStore && (r_date <= DW'(1));
  assign w_countSum  = {1'b0, r_count} + 17'(w_bytes);

  // A run ends either on a non-contiguous store or when the idle budget runs out.
  assign w_commit     = w_tracking && ((w_qualStore && !w_contig) || w_timeout);
  assign w_commitKeep = w_commit && ({1'b0, r_count} > MIN_RUN);

  assign w_liveHit = w_tracking && (r_start <= addr_i) && (addr_i <= r_end);

  always_comb begin
    w_wrRange            = '0;
    w_wrRange.start_addr = HOM_ADDR_W'(r_start);
    w_wrRange.end_addr   = HOM_ADDR_W'(r_end);
    w_wrRange.valid      = 1'b1;
  end

  hom_range_buf #(
    .NR_RANGES (NR_RANGES)
  ) u_rangeBuf (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .wr_en_i       (w_commitKeep),
    .wr_range_i    (w_wrRange),
    .lookup_addr_i (HOM_ADDR_W'(addr_i)),
    .hit_o         (w_bufHit),
    .lost_o        (w_bufLost),
    .used_o        (used_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= HOM_ST_IDLE;
      r_start <= '0;
      r_end   <= '0;
      r_count <= '0;
      r_date  <= '0;
    end else if (flush_i) begin
      r_state <= HOM_ST_IDLE;
      r_start <= '0;
      r_end   <= '0;
      r_count <= '0;
      r_date  <= '0;
    end else if (w_qualStore) begin
      if (w_tracking && w_contig) begin
        r_end   <= addr_i;
        r_count <= w_countSum[16] ? 16'hFFFF : w_countSum[15:0];
        r_date  <= DATE_RELOAD;
      end else begin
        r_state <= HOM_ST_TRACK;
        r_start <= addr_i;
        r_end   <= addr_i;
        r_count <= '0;
        r_date  <= DATE_RELOAD;
      end
    end else if (w_tracking && w_nonStore) begin
      if (w_timeout) begin
        r_state <= HOM_ST_IDLE;
        r_date  <= '0;
      end else begin
        r_date  <= r_date - DW'(1);
      end
    end
  end

  // Lookups use the pre-commit buffer contents; JALR consumes the taint.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_taint <= 1'b0;
      r_crash <= 1'b0;
      r_drop  <= 1'b0;
    end else if (flush_i) begin
      r_taint <= 1'b0;
      r_crash <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_crash <= 1'b0;
      if (valid_i && (op_i == LOAD)) begin
        r_taint <= w_bufHit || w_liveHit;
      end else if (valid_i && (op_i == JALR)) begin
        r_crash <= r_taint && en_crash_i;
        r_taint <= 1'b0;
      end
      if (w_bufLost) r_drop <= 1'b1;
    end
  end

  assign crash_o    = r_crash;
  assign tracking_o = w_tracking;
  assign taint_o    = r_taint;
  assign drop_o     = r_drop;

endmodule

// File: tb/tb_heap_overflow_monitor.sv
// Directed bench for heap_overflow_monitor with hand-computed expectations.
// Honors HOM_OVERWRITE_OLDEST_EN for the full-buffer expectations.
module tb_heap_overflow_monitor;
  import insa_sec_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  hom_op_t     op_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i;
  logic        stack_base_i;
  logic        flush_i;
  logic        en_crash_i;
  logic        crash_o;
  logic        tracking_o;
  logic        taint_o;
  logic [2:0]  used_o;
  logic        drop_o;

  int vecCount  = 0;
  int failCount = 0;

  heap_overflow_monitor dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .op_i         (op_i),
    .size_i       (size_i),
    .addr_i       (addr_i),
    .stack_base_i (stack_base_i),
    .flush_i      (flush_i),
    .en_crash_i   (en_crash_i),
    .crash_o      (crash_o),
    .tracking_o   (tracking_o),
    .taint_o      (taint_o),
    .used_o       (used_o),
    .drop_o       (drop_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one op for one clock edge; outputs are stable 1 ns after that edge.
  task automatic applyStimulus(input logic v, input hom_op_t op, input logic [1:0] size,
                               input logic [31:0] addr, input logic sb,
                               input logic crashEn, input logic flush);
    valid_i      = v;
    op_i         = op;
    size_i       = size;
    addr_i       = addr;
    stack_base_i = sb;
    en_crash_i   = crashEn;
    flush_i      = flush;
    @(posedge clk_i);
    #1;
    valid_i      = 1'b0;
    flush_i      = 1'b0;
    stack_base_i = 1'b0;
  endtask

  task automatic sw(input logic [31:0] addr);
    applyStimulus(1'b1, STORE, HOM_SZ_WORD, addr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [31:0] addr);
    applyStimulus(1'b1, LOAD, HOM_SZ_WORD, addr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic others(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, OTHER, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, OTHER, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic swRun(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) sw(base + 32'(4 * k));
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; op_i = OTHER; size_i = 2'd0; addr_i = '0;
    stack_base_i = 1'b0; flush_i = 1'b0; en_crash_i = 1'b0;
    #12;
    checkOutput("rst_tracking", 32'(tracking_o), 32'd0);
    checkOutput("rst_taint",    32'(taint_o),    32'd0);
    checkOutput("rst_crash",    32'(crash_o),    32'd0);
    checkOutput("rst_used",     32'(used_o),     32'd0);
    checkOutput("rst_drop",     32'(drop_o),     32'd0);
    #10 rst_ni = 1'b1;

    // Eight words = 28 bytes: too short to record.
    swRun(32'h1000, 8);
    checkOutput("short_tracking", 32'(tracking_o), 32'd1);
    others(9);
    checkOutput("short_before_timeout", 32'(tracking_o), 32'd1);
    others(1);
    checkOutput("short_timeout_idle", 32'(tracking_o), 32'd0);
    checkOutput("short_no_commit",    32'(used_o),     32'd0);

    // Ten words = 36 bytes, committed by a non-contiguous store.
    swRun(32'h2000, 10);
    sw(32'h3000);
    checkOutput("long_used",     32'(used_o),     32'd1);
    checkOutput("long_restart",  32'(tracking_o), 32'd1);
    lw(32'h2010);
    checkOutput("load_taint",    32'(taint_o),    32'd1);
    applyStimulus(1'b1, JALR, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("jalr_crash",    32'(crash_o),    32'd1);
    checkOutput("jalr_clr_taint", 32'(taint_o),   32'd0);
    idle();
    checkOutput("crash_one_cycle", 32'(crash_o),  32'd0);

    // Inclusive bounds, live-run hit, crash disabled.
    lw(32'h2024);
    checkOutput("hit_end_incl",  32'(taint_o), 32'd1);
    lw(32'h2025);
    checkOutput("miss_past_end", 32'(taint_o), 32'd0);
    lw(32'h1FFF);
    checkOutput("miss_below",    32'(taint_o), 32'd0);
    lw(32'h3000);
    checkOutput("hit_live_run",  32'(taint_o), 32'd1);
    applyStimulus(1'b1, JALR, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("nocrash_disabled", 32'(crash_o), 32'd0);
    checkOutput("nocrash_clr_taint", 32'(taint_o), 32'd0);

    // Ignored stores neither restart the run nor consume the timeout budget.
    applyStimulus(1'b1, STORE, HOM_SZ_WORD, 32'h4000, 1'b1, 1'b0, 1'b0);
    checkOutput("stack_still_tracking", 32'(tracking_o), 32'd1);
    lw(32'h4000);
    checkOutput("stack_no_taint", 32'(taint_o), 32'd0);
    applyStimulus(1'b1, STORE, HOM_SZ_NONE, 32'h4000, 1'b0, 1'b0, 1'b0);
    lw(32'h4000);
    checkOutput("size3_no_taint", 32'(taint_o), 32'd0);
    checkOutput("budget_left",    32'(tracking_o), 32'd1);
    others(1);
    checkOutput("budget_spent",   32'(tracking_o), 32'd0);
    checkOutput("empty_run_discard", 32'(used_o), 32'd1);

    applyStimulus(1'b0, OTHER, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_used", 32'(used_o), 32'd0);

    // Exactly 32 bytes is not enough.
    swRun(32'h5000, 9);
    others(10);
    checkOutput("count32_no_commit", 32'(used_o), 32'd0);

    // Five committed runs into a four-entry buffer.
    for (int r = 0; r < 5; r++) begin
      swRun(32'h0001_0000 * 32'(r + 1), 10);
      others(10);
      checkOutput($sformatf("fill_used_%0d", r), 32'(used_o), (r < 4) ? 32'(r + 1) : 32'd4);
    end
`ifdef HOM_OVERWRITE_OLDEST_EN
    checkOutput("full_drop", 32'(drop_o), 32'd0);
    lw(32'h0001_0000);
    checkOutput("oldest_evicted", 32'(taint_o), 32'd0);
    lw(32'h0005_0000);
    checkOutput("newest_present", 32'(taint_o), 32'd1);
`else
    checkOutput("full_drop", 32'(drop_o), 32'd1);
    lw(32'h0001_0000);
    checkOutput("oldest_kept", 32'(taint_o), 32'd1);
    lw(32'h0005_0000);
    checkOutput("newest_lost", 32'(taint_o), 32'd0);
`endif

    // Flush beats a tainted JALR.
    lw(32'h0002_0004);
    checkOutput("pre_flush_taint", 32'(taint_o), 32'd1);
    sw(32'h7000);
    applyStimulus(1'b1, JALR, 2'd0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_crash",    32'(crash_o),    32'd0);
    checkOutput("flush_used2",    32'(used_o),     32'd0);
    checkOutput("flush_tracking", 32'(tracking_o), 32'd0);
    checkOutput("flush_taint",    32'(taint_o),    32'd0);
    checkOutput("flush_drop",     32'(drop_o),     32'd0);

    // Asynchronous reset while a crash pulse and a live run are present.
    swRun(32'h8000, 10);
    sw(32'h9000);
    lw(32'h9000);
    applyStimulus(1'b1, JALR, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_crash", 32'(crash_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_crash",    32'(crash_o),    32'd0);
    checkOutput("async_rst_tracking", 32'(tracking_o), 32'd0);
    checkOutput("async_rst_used",     32'(used_o),     32'd0);
    #3 rst_ni = 1'b1;
    lw(32'h9000);
    checkOutput("run_discarded", 32'(taint_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
